// File: rtl/alu_cmd_queue.sv
// ALU command queue: buffers {sel, op1, op2} commands in a FIFO and presents
// the head command on the ALU operand/select inputs.

package constants_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_sel_e;
endpackage

module alu_cmd_queue #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0]                 in_sel_i,
    input  logic [DWIDTH-1:0]          in_op1_i,
    input  logic [DWIDTH-1:0]          in_op2_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0]                 sel_o,
    output logic [DWIDTH-1:0]          op1_o,
    output logic [DWIDTH-1:0]          op2_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                stall_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + 2 * DWIDTH;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;

    logic push, pop;
    logic [EW-1:0] head;

    // Ready/valid come from registered occupancy only, so no in->out path exists.
    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;

        if (in_valid_i && !in_ready_o && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; the head is masked while empty,
    // so stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_sel_i, in_op1_i, in_op2_i};
        end
    end

    assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

    assign sel_o       = head[EW-1 -: 2];
    assign op1_o       = head[2*DWIDTH-1 -: DWIDTH];
    assign op2_o       = head[DWIDTH-1:0];
    assign count_o     = count_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
